// File: rtl/mhart_clint_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mhart_clint_pkg: register map, decode enum and address decoder   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mhart_clint_pkg;

  localparam int MAX_HARTS = 8;
  localparam int HART_W    = 3;

  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_LO      = 16'hBFF8;
  localparam logic [15:0] MTIME_HI      = 16'hBFFC;

  typedef enum logic [2:0] {
    MSIP    = 3'd0,
    CMP_LO  = 3'd1,
    CMP_HI  = 3'd2,
    TIME_LO = 3'd3,
    TIME_HI = 3'd4,
    BAD     = 3'd5
  } decode_e;

  typedef struct packed {
    decode_e             kind;
    logic [HART_W-1:0]   hart;
  } decode_t;

  // Anything misaligned, unmapped, or naming a hart beyond num_harts decodes to BAD.
  function automatic decode_t decode_addr(input logic [15:0] addr, input int num_harts);
    decode_t d;
    d.kind = BAD;
    d.hart = '0;
    if (addr[1:0] != 2'b00) begin
      d.kind = BAD;
    end else if (addr == MTIME_LO) begin
      d.kind = TIME_LO;
    end else if (addr == MTIME_HI) begin
      d.kind = TIME_HI;
    end else if (addr[15:5] == MSIP_BASE[15:5]) begin
      d.hart = addr[4:2];
      if ({29'd0, addr[4:2]} < num_harts) d.kind = MSIP;
    end else if (addr[15:6] == MTIMECMP_BASE[15:6]) begin
      d.hart = addr[5:3];
      if ({29'd0, addr[5:3]} < num_harts) d.kind = addr[2] ? CMP_HI : CMP_LO;
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mtime_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mtime_counter: prescaled 64-bit mtime with per-half write ports  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mtime_counter #(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] mtime
);

  localparam int                 c_PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);
  localparam logic [c_PRESC_W-1:0] c_PRESC_ONE  = c_PRESC_W'(1);

  logic [c_PRESC_W-1:0] r_presc;
  logic [63:0]          r_mtime;
  logic                 w_wrap;

  assign w_wrap = (r_presc == c_PRESC_LAST);

  // A software write to either half restarts the tick period and wins over the increment.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_presc <= '0;
      r_mtime <= '0;
    end else if (wr_lo || wr_hi) begin
      r_presc <= '0;
      if (wr_lo) r_mtime[31:0]  <= wdata;
      if (wr_hi) r_mtime[63:32] <= wdata;
    end else begin
      r_presc <= w_wrap ? '0 : r_presc + c_PRESC_ONE;
      if (w_wrap) r_mtime <= r_mtime + 64'd1;
    end
  end

  assign mtime = r_mtime;

endmodule
`default_nettype wire

// File: rtl/mhart_clint.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mhart_clint: multi-hart core-local interruptor (msip/mtimecmp)   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mhart_clint
  import mhart_clint_pkg::*;
#(
  parameter int NUM_HARTS = 2,
  parameter int TICK_DIV  = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 req,
  input  logic                 wen,
  input  logic [15:0]          addr,
  input  logic [31:0]          wdata,
  output logic                 ack,
  output logic                 err,
  output logic [31:0]          rdata,
  output logic [NUM_HARTS-1:0] timer_int,
  output logic [NUM_HARTS-1:0] soft_int
);

  logic                 r_ack;
  logic                 r_err;
  logic                 r_armed;
  logic [31:0]          r_rdata;
  logic [31:0]          w_rd;
  logic [63:0]          w_mtime;
  logic [63:0]          w_cmp [NUM_HARTS];
  logic [NUM_HARTS-1:0] w_msip;
  logic [NUM_HARTS-1:0] w_tint;
  decode_t              w_dec;
  logic                 w_accept;
  logic                 w_wr;

  assign w_dec    = decode_addr(addr, NUM_HARTS);
  // r_armed stays low until req is seen low, so a request held across reset is never served.
  assign w_accept = req & ~r_ack & r_armed;
  assign w_wr     = w_accept & wen & (w_dec.kind != BAD);

  mtime_counter #(
    .TICK_DIV (TICK_DIV)
  ) u_mtime (
    .clk   (clk),
    .n_rst (n_rst),
    .wr_lo (w_wr && (w_dec.kind == TIME_LO)),
    .wr_hi (w_wr && (w_dec.kind == TIME_HI)),
    .wdata (wdata),
    .mtime (w_mtime)
  );

  always_comb begin
    w_rd = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (w_dec.hart == HART_W'(h)) begin
        case (w_dec.kind)
          MSIP:    w_rd = {31'd0, w_msip[h]};
          CMP_LO:  w_rd = w_cmp[h][31:0];
          CMP_HI:  w_rd = w_cmp[h][63:32];
          default: ;
        endcase
      end
    end
    if (w_dec.kind == TIME_LO) w_rd = w_mtime[31:0];
    if (w_dec.kind == TIME_HI) w_rd = w_mtime[63:32];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_armed <= 1'b0;
    end else begin
      r_ack   <= w_accept;
      r_err   <= w_accept & (w_dec.kind == BAD);
      r_rdata <= (w_accept && !wen) ? w_rd : 32'd0;
      r_armed <= r_armed | ~req;
    end
  end

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    logic        r_msip;
    logic        r_tint;
    logic [63:0] r_cmp;
    logic        w_sel;

    assign w_sel = w_wr && (w_dec.hart == HART_W'(h));

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        r_msip <= 1'b0;
        r_cmp  <= '1;
        r_tint <= 1'b0;
      end else begin
        if (w_sel && (w_dec.kind == MSIP))   r_msip        <= wdata[0];
        if (w_sel && (w_dec.kind == CMP_LO)) r_cmp[31:0]   <= wdata;
        if (w_sel && (w_dec.kind == CMP_HI)) r_cmp[63:32]  <= wdata;
        r_tint <= (w_mtime >= r_cmp);
      end
    end

    assign w_msip[h] = r_msip;
    assign w_tint[h] = r_tint;
    assign w_cmp[h]  = r_cmp;
  end

  assign ack       = r_ack;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign timer_int = w_tint;
  assign soft_int  = w_msip;

endmodule
`default_nettype wire

// File: tb/tb_mhart_clint.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mhart_clint: directed vector bench for mhart_clint            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mhart_clint;

  localparam int NUM_HARTS = 2;
  localparam int TICK_DIV  = 4;

  logic        clk   = 1'b0;
  logic        n_rst = 1'b0;
  logic        req   = 1'b0;
  logic        wen   = 1'b0;
  logic [15:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic        ack;
  logic        err;
  logic [31:0] rdata;
  logic [NUM_HARTS-1:0] timer_int;
  logic [NUM_HARTS-1:0] soft_int;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mhart_clint #(
    .NUM_HARTS (NUM_HARTS),
    .TICK_DIV  (TICK_DIV)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req       (req),
    .wen       (wen),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .timer_int (timer_int),
    .soft_int  (soft_int)
  );

  typedef struct {
    string       name;
    logic        wr;
    logic [15:0] a;
    logic [31:0] d;
    logic        e_err;
    logic [31:0] e_rd;
    logic [1:0]  e_soft;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string n, input logic w, input logic [15:0] a, input logic [31:0] d,
                     input logic e_err, input logic [31:0] e_rd, input logic [1:0] e_soft);
    vec_t v;
    v.name = n; v.wr = w; v.a = a; v.d = d; v.e_err = e_err; v.e_rd = e_rd; v.e_soft = e_soft;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge where ack is seen.
  task automatic bus(input string name, input logic w, input logic [15:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e);
    logic got;
    got = 1'b0;
    req = 1'b1; wen = w; addr = a; wdata = d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    rd = rdata;
    e  = err;
    req = 1'b0; wen = 1'b0;
    if (!got) begin
      n_total++;
      $display("FAIL %s_timeout: got no ack expected ack within 8 cycles", name);
    end
  endtask

  logic [31:0] rd;
  logic        e;
  logic        seen;

  initial begin
    add("msip0_wr_ones",    1'b1, 16'h0000, 32'hFFFF_FFFF, 1'b0, 32'h0,         2'b01);
    add("msip0_rd",         1'b0, 16'h0000, 32'h0,         1'b0, 32'h1,         2'b01);
    add("msip1_wr_even",    1'b1, 16'h0004, 32'h2,         1'b0, 32'h0,         2'b01);
    add("msip1_rd0",        1'b0, 16'h0004, 32'h0,         1'b0, 32'h0,         2'b01);
    add("msip1_wr_odd",     1'b1, 16'h0004, 32'h3,         1'b0, 32'h0,         2'b11);
    add("msip1_rd1",        1'b0, 16'h0004, 32'h0,         1'b0, 32'h1,         2'b11);
    add("msip0_wr0",        1'b1, 16'h0000, 32'h0,         1'b0, 32'h0,         2'b10);
    add("rd_bad_hart_cmp",  1'b0, 16'h4010, 32'h0,         1'b1, 32'h0,         2'b10);
    add("rd_misalign",      1'b0, 16'h0002, 32'h0,         1'b1, 32'h0,         2'b10);
    add("wr_misalign_msip", 1'b1, 16'h0002, 32'h1,         1'b1, 32'h0,         2'b10);
    add("wr_bad_hart_msip", 1'b1, 16'h0008, 32'h1,         1'b1, 32'h0,         2'b10);
    add("cmp0_lo_wr",       1'b1, 16'h4000, 32'h1234_5678, 1'b0, 32'h0,         2'b10);
    add("cmp0_lo_rd",       1'b0, 16'h4000, 32'h0,         1'b0, 32'h1234_5678, 2'b10);
    add("wr_misalign_cmp",  1'b1, 16'h4006, 32'h0,         1'b1, 32'h0,         2'b10);
    add("cmp0_hi_rd",       1'b0, 16'h4004, 32'h0,         1'b0, 32'hFFFF_FFFF, 2'b10);
    add("rd_unmapped",      1'b0, 16'h8000, 32'h0,         1'b1, 32'h0,         2'b10);
    add("wr_bad_hart_cmp",  1'b1, 16'h4018, 32'h0,         1'b1, 32'h0,         2'b10);
    add("cmp1_hi_rd",       1'b0, 16'h400C, 32'h0,         1'b0, 32'hFFFF_FFFF, 2'b10);
    add("msip1_wr0",        1'b1, 16'h0004, 32'h0,         1'b0, 32'h0,         2'b00);
    add("cmp0_lo_restore",  1'b1, 16'h4000, 32'hFFFF_FFFF, 1'b0, 32'h0,         2'b00);
    add("cmp0_lo_rd2",      1'b0, 16'h4000, 32'h0,         1'b0, 32'hFFFF_FFFF, 2'b00);
    add("mtime_hi_rd",      1'b0, 16'hBFFC, 32'h0,         1'b0, 32'h0,         2'b00);

    // Reset values, then release at the t=20 negedge; 4th rising edge with n_rst=1 is t=55.
    @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_timer", timer_int, 0);
    check("rst_soft", soft_int, 0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    bus("mtime_edge4", 1'b0, 16'hBFF8, 0, rd, e);
    check("mtime_before_4th_edge", rd, 0);
    bus("mtime_after4", 1'b0, 16'hBFF8, 0, rd, e);
    check("mtime_after_4th_edge", rd, 1);
    check("timer_after_rst", timer_int, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      bus(tbl[i].name, tbl[i].wr, tbl[i].a, tbl[i].d, rd, e);
      check({tbl[i].name, "_err"}, e, tbl[i].e_err);
      check({tbl[i].name, "_rdata"}, rd, tbl[i].e_rd);
      check({tbl[i].name, "_soft"}, soft_int, tbl[i].e_soft);
      @(negedge clk);
      check({tbl[i].name, "_ack_drop"}, {ack, rdata}, 0);
    end

    // cmp1 = 20, then zero mtime; mtime reaches 20 at the 80th edge after the low write.
    bus("cmp1_lo", 1'b1, 16'h4008, 32'd20, rd, e);
    bus("cmp1_hi", 1'b1, 16'h400C, 32'd0, rd, e);
    bus("mtime_hi0", 1'b1, 16'hBFFC, 32'd0, rd, e);
    bus("mtime_lo0", 1'b1, 16'hBFF8, 32'd0, rd, e);
    repeat (80) @(negedge clk);
    check("timer_at_mtime20", timer_int, 2'b00);
    @(negedge clk);
    check("timer1_rise", timer_int, 2'b10);
    bus("cmp1_hi_raise", 1'b1, 16'h400C, 32'd1, rd, e);
    check("timer1_at_cmp_write", timer_int, 2'b10);
    @(negedge clk);
    check("timer1_after_cmp_write", timer_int, 2'b00);

    // mtime all-ones: both compares true, then wrap at the 4th edge clears them one edge later.
    bus("mtime_hi_ones", 1'b1, 16'hBFFC, 32'hFFFF_FFFF, rd, e);
    bus("mtime_lo_ones", 1'b1, 16'hBFF8, 32'hFFFF_FFFF, rd, e);
    repeat (3) @(negedge clk);
    check("timer_at_max", timer_int, 2'b11);
    @(negedge clk);
    check("timer_at_wrap_edge", timer_int, 2'b11);
    @(negedge clk);
    check("timer_after_wrap", timer_int, 2'b00);
    bus("mtime_lo_wrapped", 1'b0, 16'hBFF8, 0, rd, e);
    check("mtime_lo_wrapped", rd, 0);
    bus("mtime_hi_wrapped", 1'b0, 16'hBFFC, 0, rd, e);
    check("mtime_hi_wrapped", rd, 0);

    // Load non-reset state, then reset in the middle of a pending msip0 write.
    bus("msip1_set", 1'b1, 16'h0004, 32'h1, rd, e);
    bus("cmp0_hi0", 1'b1, 16'h4004, 32'h0, rd, e);
    bus("cmp0_lo0", 1'b1, 16'h4000, 32'h0, rd, e);
    @(negedge clk);
    check("pre_rst_timer", timer_int, 2'b01);
    check("pre_rst_soft", soft_int, 2'b10);
    req = 1'b1; wen = 1'b1; addr = 16'h0000; wdata = 32'h1;
    #2 n_rst = 1'b0;
    @(negedge clk);
    check("midreq_rst_outputs", {ack, err, rdata, timer_int, soft_int}, 0);
    @(negedge clk);
    n_rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack !== 1'b0) seen = 1'b1;
    end
    check("no_ack_after_rst", seen, 0);
    check("no_write_after_rst", soft_int, 0);
    req = 1'b0; wen = 1'b0;
    @(negedge clk);
    bus("post_rst_mtime_lo", 1'b0, 16'hBFF8, 0, rd, e);
    check("post_rst_mtime_lo", rd, 1);
    bus("post_rst_mtime_hi", 1'b0, 16'hBFFC, 0, rd, e);
    check("post_rst_mtime_hi", rd, 0);
    bus("post_rst_cmp0_lo", 1'b0, 16'h4000, 0, rd, e);
    check("post_rst_cmp0_lo", rd, 32'hFFFF_FFFF);
    bus("post_rst_cmp1_hi", 1'b0, 16'h400C, 0, rd, e);
    check("post_rst_cmp1_hi", rd, 32'hFFFF_FFFF);
    bus("post_rst_msip0", 1'b0, 16'h0000, 0, rd, e);
    check("post_rst_msip0", rd, 0);
    check("post_rst_timer", timer_int, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 time units");
    $fatal(1);
  end

endmodule
`default_nettype wire
